// File: rtl/dot_overlay_renderer.sv
// Square-dot / champion / goal-box overlay for the VGA path. Processor writes land in a
// shadow file, which is copied to the displayed file only at a frame boundary.
module dot_overlay_renderer #(
  parameter int          NUM_DOTS    = 20,
  parameter int          ID_W        = 6,
  parameter int          DOT_SIZE    = 2,
  parameter int          GOAL_X      = 310,
  parameter int          GOAL_Y      = 50,
  parameter int          GOAL_SIZE   = 20,
  parameter logic [11:0] DOT_COLOR   = 12'h000,
  parameter logic [11:0] CHAMP_COLOR = 12'hF00,
  parameter logic [11:0] GOAL_COLOR  = 12'h0D0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_en,
  input  logic [9:0]      x,
  input  logic [8:0]      y,
  input  logic            active,
  input  logic            screen_end,
  input  logic [11:0]     bg_color,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [1:0]      wr_field,
  input  logic [ID_W-1:0] wr_id,
  input  logic [9:0]      wr_data,
  input  logic            commit_req,
  output logic            commit_pending,
  output logic            frame_done,
  output logic            bad_wr,
  output logic [11:0]     rgb
);

  localparam logic [10:0] GOAL_X0 = 11'(GOAL_X);
  localparam logic [10:0] GOAL_X1 = 11'(GOAL_X + GOAL_SIZE);
  localparam logic [9:0]  GOAL_Y0 = 10'(GOAL_Y);
  localparam logic [9:0]  GOAL_Y1 = 10'(GOAL_Y + GOAL_SIZE);
  localparam logic [10:0] DOT_W   = 11'(DOT_SIZE);
  localparam logic [9:0]  DOT_H   = 10'(DOT_SIZE);

  logic                commit_fire;
  logic                wr_accept;
  logic                id_ok;
  logic [ID_W-1:0]     shadow_champ;
  logic                shadow_champ_en;
  logic [ID_W-1:0]     live_champ;
  logic                live_champ_en;
  logic [9:0]          s1_x;
  logic [8:0]          s1_y;
  logic                s1_active;
  logic [11:0]         s1_bg;
  logic [NUM_DOTS-1:0] hit;
  logic [NUM_DOTS-1:0] champ_sel;
  logic                champ_hit;
  logic                goal_hit;

  // A copy and a shadow write never share a cycle, so the copy always sees settled data.
  assign commit_fire = commit_pending & pix_en & screen_end;
  assign wr_ready    = ~commit_fire;
  assign wr_accept   = wr_valid & wr_ready;
  assign id_ok       = (wr_id < ID_W'(NUM_DOTS));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOTS; gi++) begin : g_dot
      logic [9:0] shadow_x, live_x;
      logic [8:0] shadow_y, live_y;
      logic       shadow_en, live_en;
      logic       sel;

      assign sel = wr_accept && (wr_id == ID_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shadow_x  <= 10'd320;
          shadow_y  <= 9'd240;
          shadow_en <= 1'b0;
          live_x    <= 10'd320;
          live_y    <= 9'd240;
          live_en   <= 1'b0;
        end else begin
          if (sel && wr_field == 2'd0) shadow_x  <= wr_data;
          if (sel && wr_field == 2'd1) shadow_y  <= wr_data[8:0];
          if (sel && wr_field == 2'd2) shadow_en <= wr_data[0];
          if (commit_fire) begin
            live_x  <= shadow_x;
            live_y  <= shadow_y;
            live_en <= shadow_en;
          end
        end
      end

      // One extra bit on each side keeps a dot near the right/bottom edge from wrapping to 0.
      assign hit[gi] = live_en
          && ({1'b0, s1_x} >= {1'b0, live_x}) && ({1'b0, s1_x} < ({1'b0, live_x} + DOT_W))
          && ({1'b0, s1_y} >= {1'b0, live_y}) && ({1'b0, s1_y} < ({1'b0, live_y} + DOT_H));
      assign champ_sel[gi] = (live_champ == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_champ    <= '0;
      shadow_champ_en <= 1'b0;
      live_champ      <= '0;
      live_champ_en   <= 1'b0;
      commit_pending  <= 1'b0;
      frame_done      <= 1'b0;
      bad_wr          <= 1'b0;
    end else begin
      if (wr_accept && wr_field == 2'd3) begin
        if (id_ok) begin
          shadow_champ    <= wr_id;
          shadow_champ_en <= 1'b1;
        end else begin
          shadow_champ_en <= 1'b0;
        end
      end
      if (wr_accept && wr_field != 2'd3 && !id_ok) bad_wr <= 1'b1;
      if (commit_fire) begin
        live_champ    <= shadow_champ;
        live_champ_en <= shadow_champ_en;
      end
      // A request landing on the firing cycle stays pending for the following frame.
      commit_pending <= commit_req | (commit_pending & ~commit_fire);
      frame_done     <= commit_fire;
    end
  end

  assign champ_hit = live_champ_en && |(hit & champ_sel);
  assign goal_hit  = ({1'b0, s1_x} >= GOAL_X0) && ({1'b0, s1_x} < GOAL_X1)
                  && ({1'b0, s1_y} >= GOAL_Y0) && ({1'b0, s1_y} < GOAL_Y1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_x      <= '0;
      s1_y      <= '0;
      s1_active <= 1'b0;
      s1_bg     <= '0;
      rgb       <= '0;
    end else if (pix_en) begin
      s1_x      <= x;
      s1_y      <= y;
      s1_active <= active;
      s1_bg     <= bg_color;
      if (!s1_active)    rgb <= 12'h000;
      else if (champ_hit) rgb <= CHAMP_COLOR;
      else if (|hit)     rgb <= DOT_COLOR;
      else if (goal_hit) rgb <= GOAL_COLOR;
      else               rgb <= s1_bg;
    end
  end

endmodule

// File: tb/tb_dot_overlay_renderer.sv
// Bench for dot_overlay_renderer: directed scenarios plus random traffic, with the pixel
// output checked by a monitor against a queue filled from a shadow/live reference model.
module tb_dot_overlay_renderer;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic        screen_end;
  logic [11:0] bg_color;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_field;
  logic [5:0]  wr_id;
  logic [9:0]  wr_data;
  logic        commit_req;
  logic        commit_pending;
  logic        frame_done;
  logic        bad_wr;
  logic [11:0] rgb;

  dot_overlay_renderer dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
    .screen_end(screen_end), .bg_color(bg_color), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_field(wr_field), .wr_id(wr_id), .wr_data(wr_data), .commit_req(commit_req),
    .commit_pending(commit_pending), .frame_done(frame_done), .bad_wr(bad_wr), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  // Reference state: shadow (s*) and displayed (l*) files.
  int m_sx[N], m_sy[N], m_lx[N], m_ly[N];
  bit m_sen[N], m_len[N];
  int m_scid, m_lcid;
  bit m_scf, m_lcf, m_pend, m_bad;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_sx[i] = 320; m_sy[i] = 240; m_sen[i] = 0;
      m_lx[i] = 320; m_ly[i] = 240; m_len[i] = 0;
    end
    m_scid = 0; m_lcid = 0; m_scf = 0; m_lcf = 0; m_pend = 0; m_bad = 0;
  endfunction

  function automatic void model_write(int f, int id, int d);
    if (f == 3) begin
      if (id < N) begin m_scid = id; m_scf = 1; end
      else m_scf = 0;
    end else if (id >= N) begin
      m_bad = 1;
    end else if (f == 0) m_sx[id] = d % 1024;
    else if (f == 1) m_sy[id] = d % 512;
    else m_sen[id] = (d % 2) == 1;
  endfunction

  function automatic bit in_dot(int i, int px, int py);
    return m_len[i] && px >= m_lx[i] && px < m_lx[i] + 2 && py >= m_ly[i] && py < m_ly[i] + 2;
  endfunction

  function automatic logic [11:0] ref_rgb(int px, int py, bit act, logic [11:0] bg);
    bit any = 0;
    if (!act) return 12'h000;
    if (m_lcf && in_dot(m_lcid, px, py)) return 12'hF00;
    for (int i = 0; i < N; i++) if (in_dot(i, px, py)) any = 1;
    if (any) return 12'h000;
    if (px >= 310 && px < 330 && py >= 50 && py < 70) return 12'h0D0;
    return bg;
  endfunction

  // One clk cycle of stimulus; the model is advanced with the same edge semantics.
  task automatic cyc(bit pe, int px, int py, bit act, logic [11:0] bg, bit se,
                     bit wv, int wf, int wid, int wd, bit cr);
    bit fire;
    pix_en = pe; x = px[9:0]; y = py[8:0]; active = act; bg_color = bg; screen_end = se;
    wr_valid = wv; wr_field = wf[1:0]; wr_id = wid[5:0]; wr_data = wd[9:0]; commit_req = cr;
    fire = m_pend && pe && se;
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(!fire));
    if (fire) begin
      for (int i = 0; i < N; i++) begin
        m_lx[i] = m_sx[i]; m_ly[i] = m_sy[i]; m_len[i] = m_sen[i];
      end
      m_lcid = m_scid; m_lcf = m_scf;
    end
    if (wv && !fire) model_write(wf, wid, wd);
    m_pend = cr || (m_pend && !fire);
    if (pe) exp_q.push_back(ref_rgb(px, py, act, bg));
    @(posedge clk); #1;
    chk("frame_done", 32'(frame_done), 32'(fire));
    chk("commit_pending", 32'(commit_pending), 32'(m_pend));
    chk("bad_wr", 32'(bad_wr), 32'(m_bad));
  endtask

  task automatic idle();            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic pix(int px, int py, bit act); cyc(1, px, py, act, 12'($urandom), 0, 0, 0, 0, 0, 0); endtask
  task automatic frame_end();       cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic wr(int f, int id, int d); cyc(0, 0, 0, 0, 0, 0, 1, f, id, d, 0); endtask
  task automatic creq();            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask

  task automatic place(int id, int px, int py);
    wr(0, id, px); wr(1, id, py); wr(2, id, 1);
  endtask

  task automatic commit();
    creq(); idle(); frame_end(); idle();
  endtask

  task automatic scan(int x0, int x1, int y0, int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) begin
        pix(xx, yy, 1);
        if ($urandom_range(0, 1) == 1) idle();
      end
  endtask

  // Monitor: each strobe retires the pixel issued on the previous strobe.
  bit s1v = 0;
  always begin
    @(posedge clk);
    if (reset) s1v = 0;
    else if (pix_en) begin
      if (s1v) begin
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rgb_underflow: got %0h expected none at %0t", rgb, $time);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (rgb !== e) begin
            n_err++;
            $display("FAIL rgb: got %03h expected %03h at %0t", rgb, e, $time);
          end
        end
      end
      s1v = 1;
    end
  end

  initial begin
    reset = 1'b1;
    pix_en = 0; x = 0; y = 0; active = 0; screen_end = 0; bg_color = 0;
    wr_valid = 0; wr_field = 0; wr_id = 0; wr_data = 0; commit_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_pending", 32'(commit_pending), 32'h0);
    chk("reset_frame_done", 32'(frame_done), 32'h0);
    chk("reset_bad_wr", 32'(bad_wr), 32'h0);
    chk("reset_wr_ready", 32'(wr_ready), 32'h1);
    reset = 1'b0;

    // Shadow writes stay invisible until a commit.
    place(3, 100, 50);
    scan(99, 102, 49, 52);
    commit();
    scan(99, 103, 49, 52);

    // Uncommitted move is held across frames, then shows after commit.
    wr(0, 3, 200);
    for (int f = 0; f < 3; f++) begin
      scan(99, 102, 50, 51); pix(200, 50, 1); frame_end();
    end
    commit();
    scan(99, 101, 50, 50); scan(199, 202, 50, 51);

    // Champion priority, then champion cleared with an out-of-range id.
    place(0, 300, 300); place(5, 300, 300); wr(3, 5, 0);
    commit();
    scan(299, 302, 299, 301);
    wr(3, 63, 0);
    commit();
    scan(299, 301, 300, 301);

    // Goal box boundaries, dot over goal, blanking.
    place(7, 315, 55);
    commit();
    scan(314, 317, 54, 57);
    pix(329, 69, 1); pix(330, 69, 1); pix(309, 50, 1); pix(310, 50, 1); pix(329, 70, 1);
    pix(315, 55, 0); pix(320, 60, 0); pix(100, 100, 0);

    // wr_ready drops only on the firing cycle; held writes are neither lost nor doubled.
    creq();
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 10, 111, 0);
    cyc(1, 5, 5, 1, 12'h123, 1, 1, 0, 11, 222, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 11, 222, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 10, 20, 0);
    wr(1, 11, 20); wr(2, 10, 1); wr(2, 11, 1);
    // Request on the firing cycle stays pending.
    creq();
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    frame_end(); idle();
    scan(110, 113, 20, 21); scan(221, 224, 20, 20);

    // Bad id is sticky.
    wr(0, 25, 5); idle(); wr(0, 2, 5); idle();

    // Right/bottom edge dots must not wrap to column/row 0.
    place(1, 1022, 0); place(2, 0, 510);
    commit();
    pix(0, 0, 1); pix(1, 0, 1); pix(1021, 0, 1); pix(1022, 0, 1); pix(1023, 1, 1);
    pix(0, 509, 1); pix(0, 511, 1); pix(1, 510, 1); pix(2, 510, 1);

    // Random traffic in two small windows where dots and pixels overlap.
    for (int k = 0; k < 3000; k++) begin
      int px, py, wf, wid, wd;
      px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 15));
      py = ($urandom_range(0, 3) == 0) ? int'($urandom_range(504, 511)) : int'($urandom_range(0, 15));
      wf = int'($urandom_range(0, 3));
      wid = ($urandom_range(0, 15) == 0) ? 63 : int'($urandom_range(0, N - 1));
      if (wf == 0) wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 15));
      else if (wf == 1) wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(504, 511)) : int'($urandom_range(0, 15));
      else wd = int'($urandom_range(0, 1023));
      cyc($urandom_range(0, 1) == 1, px, py, $urandom_range(0, 9) != 0, 12'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, wf, wid, wd,
          $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset while a commit is pending.
    idle();
    place(2, 400, 400);
    commit();
    scan(400, 401, 400, 400);
    creq(); idle();
    #1 reset = 1'b1;
    #1;
    chk("async_rst_pending", 32'(commit_pending), 32'h0);
    chk("async_rst_frame_done", 32'(frame_done), 32'h0);
    chk("async_rst_rgb", 32'(rgb), 32'h0);
    chk("async_rst_bad_wr", 32'(bad_wr), 32'h0);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    frame_end(); idle();
    scan(400, 401, 400, 400); scan(320, 321, 240, 241);
    wr(2, 2, 1);
    commit();
    scan(319, 322, 240, 241); scan(400, 400, 400, 400);
    pix(0, 0, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
